// File: rtl/imem_loader.sv
// Instruction memory loader: accepts a streamed program image,
// then serves single-cycle instruction fetches until a halt opcode.
module imem_loader #(
    parameter int         DEPTH   = 1024,
    parameter int         AW      = 10,
    parameter logic [5:0] HALT_OP = 6'h11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [31:0]   in_data,
    input  logic          in_last,
    output logic          in_ready,
    input  logic          fetch_req,
    input  logic [31:0]   fetch_addr,
    output logic [31:0]   fetch_inst,
    output logic          fetch_valid,
    output logic          valid,
    output logic          opr_finished,
    output logic [AW:0]   loaded_words,
    output logic          load_err,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_e        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic          err_q, err_d;
    logic          arm_q, arm_d;
    logic [31:0]   inst_q, inst_d;
    logic          fv_q, fv_d;
    logic [31:0]   mem_q [DEPTH];

    logic          loading;
    logic          serving;
    logic          full;
    logic          accept;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          unused_addr;

    assign loading     = (state_q == IDLE) || (state_q == LOAD);
    assign serving     = (state_q == RUN) || (state_q == DONE);
    assign full        = (count_q == FULL);
    assign in_ready    = loading && !full;
    assign accept      = in_valid && in_ready;
    assign wr_idx      = count_q[AW-1:0];
    assign rd_idx      = fetch_addr[AW+1:2];
    assign unused_addr = ^{fetch_addr[31:AW+2], fetch_addr[1:0]};

    assign fetch_inst   = inst_q;
    assign fetch_valid  = fv_q;
    assign valid        = serving;
    assign opr_finished = (state_q == DONE);
    assign loaded_words = count_q;
    assign load_err     = err_q;
    assign state        = state_q;

    // Next-state: load handshake, overflow flag and fetch response.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        arm_d   = 1'b0;
        inst_d  = inst_q;
        fv_d    = 1'b0;
        if (accept) begin
            count_d = count_q + 1'b1;
            if (in_last) begin
                state_d = RUN;
            end else if (count_d == FULL) begin
                // Memory filled without a terminating word: the
                // source may still be offering data next cycle.
                state_d = RUN;
                arm_d   = 1'b1;
            end else begin
                state_d = LOAD;
            end
        end
        if (arm_q && in_valid) begin
            err_d = 1'b1;
        end
        if (serving && fetch_req) begin
            fv_d = 1'b1;
            if ({1'b0, rd_idx} < count_q) begin
                inst_d = mem_q[rd_idx];
            end else begin
                inst_d = 32'h0;
            end
            if (inst_d[31:26] == HALT_OP) begin
                state_d = DONE;
            end
        end
    end

    // Control and response registers; async active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            err_q   <= 1'b0;
            arm_q   <= 1'b0;
            inst_q  <= 32'h0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            arm_q   <= arm_d;
            inst_q  <= inst_d;
            fv_q    <= fv_d;
        end
    end

    // Program storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_idx] <= in_data;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: default-depth and 4-word
// instances, with queued expected fetch results.
module tb_imem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_rst, a_iv, a_il, a_ir, a_fr, a_fv;
    logic        a_valid, a_fin, a_err;
    logic [31:0] a_id, a_fa, a_fi;
    logic [10:0] a_lw;
    logic [1:0]  a_st;

    logic        b_rst, b_iv, b_il, b_ir, b_fr, b_fv;
    logic        b_valid, b_fin, b_err;
    logic [31:0] b_id, b_fa, b_fi;
    logic [2:0]  b_lw;
    logic [1:0]  b_st;

    logic [31:0] a_model[$];
    logic [31:0] b_model[$];
    logic [31:0] a_exp[$];
    logic [31:0] b_exp[$];

    imem_loader dut_a (
        .clk(clk), .reset(a_rst),
        .in_valid(a_iv), .in_data(a_id), .in_last(a_il),
        .in_ready(a_ir),
        .fetch_req(a_fr), .fetch_addr(a_fa),
        .fetch_inst(a_fi), .fetch_valid(a_fv),
        .valid(a_valid), .opr_finished(a_fin),
        .loaded_words(a_lw), .load_err(a_err), .state(a_st)
    );

    imem_loader #(.DEPTH(4), .AW(2)) dut_b (
        .clk(clk), .reset(b_rst),
        .in_valid(b_iv), .in_data(b_id), .in_last(b_il),
        .in_ready(b_ir),
        .fetch_req(b_fr), .fetch_addr(b_fa),
        .fetch_inst(b_fi), .fetch_valid(b_fv),
        .valid(b_valid), .opr_finished(b_fin),
        .loaded_words(b_lw), .load_err(b_err), .state(b_st)
    );

    function automatic logic [31:0] ref_a(input logic [31:0] addr);
        int idx;
        idx = int'(addr[11:2]);
        if (idx < a_model.size()) return a_model[idx];
        return 32'h0;
    endfunction

    function automatic logic [31:0] ref_b(input logic [31:0] addr);
        int idx;
        idx = int'(addr[3:2]);
        if (idx < b_model.size()) return b_model[idx];
        return 32'h0;
    endfunction

    task automatic reset_a();
        @(negedge clk);
        a_rst = 1'b0; a_iv = 1'b0; a_il = 1'b0; a_fr = 1'b0;
        a_model.delete();
        @(negedge clk);
        a_rst = 1'b1;
    endtask

    task automatic reset_b();
        @(negedge clk);
        b_rst = 1'b0; b_iv = 1'b0; b_il = 1'b0; b_fr = 1'b0;
        b_model.delete();
        @(negedge clk);
        b_rst = 1'b1;
    endtask

    task automatic test_reset();
        a_rst = 1'b0; a_iv = 1'b0; a_il = 1'b0; a_id = '0;
        a_fr = 1'b0; a_fa = '0;
        b_rst = 1'b0; b_iv = 1'b0; b_il = 1'b0; b_id = '0;
        b_fr = 1'b0; b_fa = '0;
        #1;
        checks++;
        if (a_st !== 2'd0 || a_lw !== 11'd0 || a_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got st=%0d lw=%0d v=%b want 0 0 0",
                     a_st, a_lw, a_valid);
        end
        checks++;
        if (a_fin !== 1'b0 || a_err !== 1'b0 || a_fv !== 1'b0
            || a_fi !== 32'h0) begin
            errors++;
            $display("FAIL reset_out got fin=%b err=%b fv=%b fi=%h want 0",
                     a_fin, a_err, a_fv, a_fi);
        end
        @(negedge clk);
        a_rst = 1'b1;
        b_rst = 1'b1;
        #1;
        checks++;
        if (a_ir !== 1'b1 || b_ir !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got a=%b b=%b want 1", a_ir, b_ir);
        end
    endtask

    task automatic test_load();
        logic [31:0] w [3];
        w[0] = 32'h20010005;
        w[1] = 32'h20020003;
        w[2] = 32'h44000000;
        a_fr = 1'b1;
        a_fa = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (a_ir !== 1'b1) begin
                errors++;
                $display("FAIL load_ready word %0d got %b want 1", i, a_ir);
            end
            if (i == 1) begin
                checks++;
                if (a_st !== 2'd1 || a_lw !== 11'd1 || a_fv !== 1'b0) begin
                    errors++;
                    $display("FAIL load_mid got st=%0d lw=%0d fv=%b want 1 1 0",
                             a_st, a_lw, a_fv);
                end
            end
            a_iv = 1'b1;
            a_id = w[i];
            a_il = (i == 2);
            a_model.push_back(w[i]);
        end
        @(negedge clk);
        a_iv = 1'b0;
        a_il = 1'b0;
        a_fr = 1'b0;
        checks++;
        if (a_st !== 2'd2 || a_lw !== 11'd3 || a_valid !== 1'b1
            || a_fv !== 1'b0) begin
            errors++;
            $display("FAIL load_done got st=%0d lw=%0d v=%b fv=%b want 2 3 1 0",
                     a_st, a_lw, a_valid, a_fv);
        end
    endtask

    task automatic test_fetch_nop();
        logic [31:0] e;
        @(negedge clk);
        a_fr = 1'b1;
        a_fa = 32'h40;
        a_exp.push_back(ref_a(32'h40));
        @(negedge clk);
        a_fr = 1'b0;
        e = a_exp.pop_front();
        checks++;
        if (a_fv !== 1'b1 || a_fi !== e || a_fin !== 1'b0
            || a_st !== 2'd2) begin
            errors++;
            $display("FAIL fetch_nop got fv=%b fi=%h fin=%b st=%0d want 1 %h 0 2",
                     a_fv, a_fi, a_fin, a_st, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        e = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = a_exp.pop_front();
                checks++;
                if (a_fv !== 1'b1 || a_fi !== e) begin
                    errors++;
                    $display("FAIL b2b_%0d got fv=%b fi=%h want 1 %h",
                             i, a_fv, a_fi, e);
                end
                checks++;
                if (a_fin !== (i == 3)) begin
                    errors++;
                    $display("FAIL b2b_fin_%0d got %b want %b",
                             i, a_fin, (i == 3));
                end
            end
            if (i < 3) begin
                a_fr = 1'b1;
                a_fa = 32'(i * 4);
                a_exp.push_back(ref_a(32'(i * 4)));
            end else begin
                a_fr = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (a_fv !== 1'b0 || a_fi !== e || a_st !== 2'd3) begin
            errors++;
            $display("FAIL hold got fv=%b fi=%h st=%0d want 0 %h 3",
                     a_fv, a_fi, a_st, e);
        end
        a_fr = 1'b1;
        a_fa = 32'h4;
        a_exp.push_back(ref_a(32'h4));
        @(negedge clk);
        a_fr = 1'b0;
        e = a_exp.pop_front();
        checks++;
        if (a_fv !== 1'b1 || a_fi !== e || a_st !== 2'd3) begin
            errors++;
            $display("FAIL done_fetch got fv=%b fi=%h st=%0d want 1 %h 3",
                     a_fv, a_fi, a_st, e);
        end
    endtask

    task automatic test_reset_midload();
        logic [31:0] e;
        reset_a();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            a_iv = 1'b1;
            a_id = 32'h10000000 + 32'(i);
            a_il = 1'b0;
            a_model.push_back(a_id);
        end
        @(negedge clk);
        a_iv = 1'b0;
        checks++;
        if (a_st !== 2'd1 || a_lw !== 11'd2) begin
            errors++;
            $display("FAIL midload got st=%0d lw=%0d want 1 2", a_st, a_lw);
        end
        a_rst = 1'b0;
        a_model.delete();
        #1;
        checks++;
        if (a_st !== 2'd0 || a_lw !== 11'd0 || a_valid !== 1'b0) begin
            errors++;
            $display("FAIL midload_rst got st=%0d lw=%0d v=%b want 0 0 0",
                     a_st, a_lw, a_valid);
        end
        @(negedge clk);
        a_rst = 1'b1;
        @(negedge clk);
        a_iv = 1'b1;
        a_id = 32'h0C000001;
        a_il = 1'b1;
        a_model.push_back(a_id);
        @(negedge clk);
        a_iv = 1'b0;
        a_il = 1'b0;
        checks++;
        if (a_st !== 2'd2 || a_lw !== 11'd1) begin
            errors++;
            $display("FAIL reload got st=%0d lw=%0d want 2 1", a_st, a_lw);
        end
        a_fr = 1'b1;
        a_fa = 32'h4;
        a_exp.push_back(ref_a(32'h4));
        @(negedge clk);
        a_fr = 1'b0;
        e = a_exp.pop_front();
        checks++;
        if (a_fv !== 1'b1 || a_fi !== e) begin
            errors++;
            $display("FAIL stale_word got fv=%b fi=%h want 1 %h", a_fv, a_fi, e);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] e;
        reset_b();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 4) begin
                checks++;
                if (b_st !== 2'd2 || b_ir !== 1'b0 || b_lw !== 3'd4
                    || b_err !== 1'b0) begin
                    errors++;
                    $display("FAIL full got st=%0d ir=%b lw=%0d err=%b want 2 0 4 0",
                             b_st, b_ir, b_lw, b_err);
                end
            end
            b_iv = 1'b1;
            b_id = 32'hB0000000 + 32'(i);
            b_il = 1'b0;
            if (i < 4) b_model.push_back(b_id);
        end
        @(negedge clk);
        b_iv = 1'b0;
        checks++;
        if (b_err !== 1'b1 || b_lw !== 3'd4) begin
            errors++;
            $display("FAIL overflow got err=%b lw=%0d want 1 4", b_err, b_lw);
        end
        b_fr = 1'b1;
        b_fa = 32'hC;
        b_exp.push_back(ref_b(32'hC));
        @(negedge clk);
        b_fa = 32'h10;
        b_exp.push_back(ref_b(32'h10));
        e = b_exp.pop_front();
        checks++;
        if (b_fv !== 1'b1 || b_fi !== e) begin
            errors++;
            $display("FAIL last_word got fv=%b fi=%h want 1 %h", b_fv, b_fi, e);
        end
        @(negedge clk);
        b_fr = 1'b0;
        e = b_exp.pop_front();
        checks++;
        if (b_fv !== 1'b1 || b_fi !== e) begin
            errors++;
            $display("FAIL alias got fv=%b fi=%h want 1 %h", b_fv, b_fi, e);
        end
    endtask

    task automatic test_fill_last();
        reset_b();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b_iv = 1'b1;
            b_id = 32'hC0000000 + 32'(i);
            b_il = (i == 3);
            b_model.push_back(b_id);
        end
        @(negedge clk);
        b_iv = 1'b0;
        b_il = 1'b0;
        checks++;
        if (b_st !== 2'd2 || b_err !== 1'b0 || b_lw !== 3'd4
            || b_ir !== 1'b0) begin
            errors++;
            $display("FAIL fill_last got st=%0d err=%b lw=%0d ir=%b want 2 0 4 0",
                     b_st, b_err, b_lw, b_ir);
        end
        @(negedge clk);
        checks++;
        if (b_err !== 1'b0) begin
            errors++;
            $display("FAIL fill_last_err got %b want 0", b_err);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_fetch_nop();
        test_back_to_back();
        test_reset_midload();
        test_overflow();
        test_fill_last();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 1024, instruction memory depth in 32-bit words.
REQ-002 Parameter AW, default 10, word-address width; DEPTH SHALL equal 2**AW.
REQ-003 Parameter HALT_OP, default 6'h11, opcode value that terminates a run.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  load stream word present.
REQ-007 in_data  input  32  load stream instruction word.
REQ-008 in_last  input  1  qualifies in_data as final word of program image.
REQ-009 in_ready  output  1  loader accepts a word this cycle.
REQ-010 fetch_req  input  1  fetch stage read request.
REQ-011 fetch_addr  input  32  byte PC; word index = fetch_addr[AW+1:2], bits [1:0] ignored.
REQ-012 fetch_inst  output  32  registered instruction for the previous-cycle request.
REQ-013 fetch_valid  output  1  fetch_inst valid this cycle.
REQ-014 valid  output  1  program loaded; pipeline may run.
REQ-015 opr_finished  output  1  HALT_OP instruction delivered; run complete.
REQ-016 loaded_words  output  AW+1  count of words written.
REQ-017 load_err  output  1  sticky: word offered while memory full.
REQ-018 state  output  2  current FSM state encoding.

Function
REQ-019 FSM states SHALL be IDLE=0, LOAD=1, RUN=2, DONE=3.
REQ-020 Handshake: word accepted iff in_valid && in_ready at rising edge; in_data written to mem[loaded_words], loaded_words incremented same edge.
REQ-021 in_ready SHALL be 1 in IDLE and LOAD while loaded_words < DEPTH, else 0.
REQ-022 IDLE -> LOAD on first accepted word without in_last; IDLE -> RUN on accepted word with in_last.
REQ-023 LOAD -> RUN on accepted word with in_last, or when the accepted word makes loaded_words == DEPTH.
REQ-024 in_last on the word that fills memory SHALL go to RUN with load_err unchanged (no error).
REQ-025 in_valid high while loaded_words == DEPTH in LOAD/RUN-entry cycle SHALL set load_err; word discarded, count unchanged.
REQ-026 valid SHALL be 1 in RUN and DONE, 0 otherwise; in_valid in RUN/DONE ignored, no memory write, load_err only per REQ-025.
REQ-027 Fetch latency exactly 1 cycle: fetch_req at edge N -> fetch_inst/fetch_valid valid during cycle N+1; fetch_valid=0 cycles without request.
REQ-028 Fetches SHALL be served only in RUN and DONE; fetch_req in IDLE/LOAD yields fetch_valid=0.
REQ-029 Word index >= loaded_words SHALL return fetch_inst=32'h0 (NOP) with fetch_valid=1.
REQ-030 Word index >= DEPTH cannot occur (index truncated to AW bits); aliasing is defined behaviour.
REQ-031 When a returned fetch_inst[31:26] == HALT_OP, state SHALL become DONE on the same edge fetch_valid rises; opr_finished=1 from that cycle on.
REQ-032 DONE continues serving fetches per REQ-027; DONE exits only by reset.
REQ-033 Back-to-back fetch_req every cycle SHALL be sustained at one instruction per cycle.
REQ-034 fetch_inst SHALL hold its last value when fetch_valid=0.

Reset
REQ-035 reset low SHALL immediately force state=IDLE, loaded_words=0, valid=0, opr_finished=0, load_err=0, fetch_valid=0, fetch_inst=0, in_ready=1 after release.
REQ-036 Memory contents are not cleared by reset; loaded_words=0 makes them unreachable (REQ-029).
REQ-037 reset asserted mid-load or mid-run SHALL abandon the operation; next load starts at word 0.

Verification
REQ-038 Load 3 words 0x20010005, 0x20020003, 0x44000000 (last on third) -> loaded_words=3, state RUN, valid=1 the cycle after third accept.
REQ-039 After REQ-038, fetch_req with addr 0,4,8 on consecutive cycles -> fetch_inst 0x20010005, 0x20020003, 0x44000000 one cycle later each; opr_finished=1 with third.
REQ-040 Fetch addr 0x40 after 3-word load -> fetch_inst=0, fetch_valid=1, opr_finished stays 0.
REQ-041 DEPTH=4: stream 5 words no in_last -> RUN after 4th, in_ready=0, 5th held valid sets load_err=1, loaded_words=4.
REQ-042 Assert reset during LOAD after 2 words -> state=IDLE, loaded_words=0, valid=0 immediately; fresh 1-word load with in_last -> RUN.
REQ-043 DEPTH=4: in_last on 4th word -> RUN, load_err=0.
